// File: rtl/count_seq_checker.sv
//==============================================================================
// Module   : count_seq_checker
// Brief    : Checks that an asynchronous pad count bus advances by +1 per step;
//            reports lock, sequence errors and wraps. Optional deglitch filter
//            enabled by defining COUNT_SEQ_DEGLITCH_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module count_seq_checker #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clear,
    output logic [WIDTH-1:0] io_oeb,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] wrap_count,
    output logic [WIDTH-1:0] last_value
);

    localparam logic [1:0]       c_ST_INIT   = 2'd0;
    localparam logic [1:0]       c_ST_HUNT   = 2'd1;
    localparam logic [1:0]       c_ST_LOCKED = 2'd2;
    localparam logic [ERR_W-1:0] c_CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] c_VAL_MAX   = '1;
    localparam logic [3:0]       c_LOCK_CNT  = 4'(LOCK_COUNT);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [1:0]       r_state;
    logic [3:0]       r_good_run;
    logic [WIDTH-1:0] r_last;
    logic             r_locked;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_cnt;
    logic [ERR_W-1:0] r_wrap_cnt;

    logic             w_eligible;
    logic             w_step;
    logic             w_good;
    logic [1:0]       w_state_nxt;
    logic [3:0]       w_good_run_nxt;
    logic [WIDTH-1:0] w_last_nxt;
    logic             w_err_pulse_nxt;
    logic             w_err_inc;
    logic             w_wrap_inc;

    // Synchronizer flops carry no reset so INIT captures the live bus value.
    always_ff @(posedge clk) begin
        r_s1 <= count_in;
        r_s2 <= r_s1;
    end

`ifdef COUNT_SEQ_DEGLITCH_EN
    logic [WIDTH-1:0] r_s3;

    always_ff @(posedge clk) begin
        r_s3 <= r_s2;
    end

    // Only a value stable for two cycles may form a step.
    assign w_eligible = (r_s2 == r_s3);
`else
    assign w_eligible = 1'b1;
`endif

    assign w_step = w_eligible && (r_s2 != r_last);
    assign w_good = (r_s2 == WIDTH'(r_last + 1'b1));

    always_comb begin
        w_state_nxt     = r_state;
        w_good_run_nxt  = r_good_run;
        w_last_nxt      = r_last;
        w_err_pulse_nxt = 1'b0;
        w_err_inc       = 1'b0;
        w_wrap_inc      = 1'b0;
        case (r_state)
            c_ST_INIT: begin
                w_last_nxt  = r_s2;
                w_state_nxt = c_ST_HUNT;
            end
            c_ST_HUNT: begin
                if (w_step) begin
                    w_last_nxt = r_s2;
                    if (w_good) begin
                        w_good_run_nxt = r_good_run + 4'd1;
                        if ((r_good_run + 4'd1) == c_LOCK_CNT) begin
                            w_state_nxt = c_ST_LOCKED;
                        end
                    end else begin
                        w_good_run_nxt = 4'd0;
                    end
                end
            end
            c_ST_LOCKED: begin
                if (w_step) begin
                    w_last_nxt = r_s2;
                    if (w_good) begin
                        w_wrap_inc = (r_last == c_VAL_MAX);
                    end else begin
                        w_err_pulse_nxt = 1'b1;
                        w_err_inc       = 1'b1;
                        w_good_run_nxt  = 4'd0;
                        w_state_nxt     = c_ST_HUNT;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_INIT;
            r_good_run  <= 4'd0;
            r_last      <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
            r_wrap_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_good_run  <= w_good_run_nxt;
            r_last      <= w_last_nxt;
            r_locked    <= (w_state_nxt == c_ST_LOCKED);
            r_err_pulse <= w_err_pulse_nxt;
            // Clear beats a coincident increment; counters saturate.
            if (clear) begin
                r_err_cnt  <= '0;
                r_wrap_cnt <= '0;
            end else begin
                if (w_err_inc && (r_err_cnt != c_CNT_MAX)) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
                if (w_wrap_inc && (r_wrap_cnt != c_CNT_MAX)) begin
                    r_wrap_cnt <= r_wrap_cnt + 1'b1;
                end
            end
        end
    end

    assign io_oeb     = '1;
    assign locked     = r_locked;
    assign err_pulse  = r_err_pulse;
    assign err_count  = r_err_cnt;
    assign wrap_count = r_wrap_cnt;
    assign last_value = r_last;

endmodule

`default_nettype wire
